// File: rtl/pacoblaze_scratch_arbiter.sv
// Two-port round-robin arbiter in front of a single-port scratch RAM.
// After reset the RAM is zero-filled before any request is serviced.
module pacoblaze_scratch_arbiter #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [DEPTH-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [DEPTH-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic             init_done,
    output logic [DEPTH-1:0] ram_address,
    output logic             ram_write_enable,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state;
    logic [DEPTH-1:0] counter;
    logic             last_b;

    // Tie goes to whichever port was not granted most recently.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state == RUN) begin
            if (a_req && b_req) begin
                a_gnt = last_b;
                b_gnt = ~last_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_data_in      = '0;
        if (state == CLEAR) begin
            ram_write_enable = 1'b1;
            ram_address      = counter;
        end else if (a_gnt) begin
            ram_write_enable = a_we;
            ram_address      = a_addr;
            ram_data_in      = a_wdata;
        end else if (b_gnt) begin
            ram_write_enable = b_we;
            ram_address      = b_addr;
            ram_data_in      = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            counter   <= '0;
            last_b    <= 1'b1;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            case (state)
                CLEAR: begin
                    counter <= counter + 1'b1;
                    if (&counter) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (a_gnt) begin
                        last_b <= 1'b0;
                        if (!a_we) begin
                            a_rdata  <= ram_data_out;
                            a_rvalid <= 1'b1;
                        end
                    end
                    if (b_gnt) begin
                        last_b <= 1'b1;
                        if (!b_we) begin
                            b_rdata  <= ram_data_out;
                            b_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_pacoblaze_scratch_arbiter.sv
// Directed bench for pacoblaze_scratch_arbiter with a behavioural scratch RAM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pacoblaze_scratch_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
    logic [7:0] a_rdata, b_rdata;
    logic [5:0] ram_address;
    logic       ram_write_enable;
    logic [7:0] ram_data_in, ram_data_out;
    logic [7:0] mem [64];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pacoblaze_scratch_arbiter #(.DEPTH(6), .WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_done(init_done),
        .ram_address(ram_address), .ram_write_enable(ram_write_enable),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // Single-port RAM: combinational read, synchronous write.
    always @(posedge clk) if (ram_write_enable) mem[ram_address] <= ram_data_in;
    assign ram_data_out = mem[ram_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered on the falling edge at which reset was released.
    task automatic do_clear(input logic hold_reqs);
        a_req = hold_reqs;
        b_req = hold_reqs;
        for (int i = 0; i < 64; i++) begin
            #1;
            check("clr_we",   32'(ram_write_enable), 1);
            check("clr_addr", 32'(ram_address), i);
            check("clr_data", 32'(ram_data_in), 0);
            check("clr_gnt",  32'({a_gnt, b_gnt}), 0);
            check("clr_init", 32'(init_done), 0);
            @(negedge clk);
        end
        #1;
        check("init_done", 32'(init_done), 1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_init",   32'(init_done), 0);
        check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 0);
        check("rst_rdata",  32'({a_rdata, b_rdata}), 0);
        @(negedge clk);
        reset = 1'b1;
        do_clear(1'b0);

        // Continuous contention: A first (pointer resets to B), then alternating.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 6'h11;
        b_req = 1; b_we = 0; b_addr = 6'h22;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_agnt", 32'(a_gnt), 32'(k % 2 == 0));
            check("rr_bgnt", 32'(b_gnt), 32'(k % 2 == 1));
            check("rr_addr", 32'(ram_address), (k % 2 == 0) ? 32'h11 : 32'h22);
            if (k > 0) check("rr_arvalid", 32'(a_rvalid), 32'(k % 2 == 1));
            @(negedge clk);
        end
        a_req = 0; b_req = 0;
        #1;
        check("rr_brvalid", 32'(b_rvalid), 1);
        check("rr_rdata",   32'({a_rdata, b_rdata}), 0);

        // A writes 0x5A to 3, B reads it back on the very next cycle.
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
        #1;
        check("wr_agnt", 32'({a_gnt, b_gnt}), 32'b10);
        check("wr_we",   32'(ram_write_enable), 1);
        check("wr_addr", 32'(ram_address), 3);
        check("wr_data", 32'(ram_data_in), 32'h5A);
        @(negedge clk);
        a_req = 0; b_req = 1; b_we = 0; b_addr = 3;
        #1;
        check("rd_bgnt", 32'({a_gnt, b_gnt}), 32'b01);
        check("rd_we",   32'(ram_write_enable), 0);
        check("rd_addr", 32'(ram_address), 3);
        @(negedge clk);
        b_req = 0;
        #1;
        check("rd_brvalid", 32'(b_rvalid), 1);
        check("rd_brdata",  32'(b_rdata), 32'h5A);
        check("rd_arvalid", 32'(a_rvalid), 0);
        check("idle_ram",   32'({ram_write_enable, ram_address, ram_data_in}), 0);
        @(negedge clk);
        #1;
        check("rd_bpulse", 32'(b_rvalid), 0);
        check("rd_bhold",  32'(b_rdata), 32'h5A);

        // A reads 3 then, holding req, reads uninitialised 10.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 3;
        #1;
        check("ard_gnt", 32'(a_gnt), 1);
        @(negedge clk);
        a_addr = 10;
        #1;
        check("ard_regnt",  32'(a_gnt), 1);
        check("ard_rvalid", 32'(a_rvalid), 1);
        check("ard_rdata3", 32'(a_rdata), 32'h5A);
        @(negedge clk);
        a_req = 0;
        #1;
        check("ard_rvalid10", 32'(a_rvalid), 1);
        check("ard_rdata10",  32'(a_rdata), 0);
        @(negedge clk);
        #1;
        check("ard_pulse", 32'(a_rvalid), 0);

        // B read leaves pointer on B; tie then goes to A, B drops out.
        @(negedge clk);
        b_req = 1; b_we = 0; b_addr = 10;
        #1;
        check("ptr_bgnt", 32'(b_gnt), 1);
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 5; a_wdata = 8'h33; b_addr = 7;
        #1;
        check("drop_gnt",  32'({a_gnt, b_gnt}), 32'b10);
        check("drop_addr", 32'(ram_address), 5);
        @(negedge clk);
        a_req = 0; b_req = 0;
        #1;
        check("drop_brvalid", 32'(b_rvalid), 0);
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 1; b_req = 1; b_addr = 2;
        #1;
        check("ptr_on_a", 32'({a_gnt, b_gnt}), 32'b01);
        check("ptr_addr", 32'(ram_address), 2);
        @(negedge clk);
        b_req = 0; a_addr = 5;

        // Reset mid-read: no rvalid, immediate clear state.
        #1;
        check("abort_gnt", 32'(a_gnt), 1);
        reset = 1'b0;
        #1;
        check("abort_init",  32'(init_done), 0);
        check("abort_agnt",  32'(a_gnt), 0);
        check("abort_ram",   32'({ram_write_enable, ram_address}), 32'h40);
        @(negedge clk);
        #1;
        check("abort_rvalid", 32'({a_rvalid, b_rvalid}), 0);
        check("abort_rdata",  32'({a_rdata, b_rdata}), 0);
        @(negedge clk);
        reset = 1'b1;
        a_req = 1; b_req = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("part_addr", 32'(ram_address), i);
            check("part_gnt",  32'({a_gnt, b_gnt}), 0);
            @(negedge clk);
        end
        #1;
        check("part_addr20", 32'(ram_address), 20);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_clear(1'b1);

        // Address 5 held 0x33 before the re-clear.
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 5;
        #1;
        check("post_gnt", 32'({a_gnt, b_gnt}), 32'b10);
        @(negedge clk);
        a_req = 0;
        #1;
        check("post_rvalid", 32'(a_rvalid), 1);
        check("post_rdata",  32'(a_rdata), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
